// File: rtl/twisted_ring_pkg.sv
`default_nettype none
// ============================================================================
// Module   : twisted_ring_pkg
// Purpose  : Shared mode/direction encodings and reset-state helper for the
//            twisted ring counter.
// Revision : 1.0 - initial release
// ============================================================================
package twisted_ring_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_FWD      = 1'b0;
   localparam logic DIR_REV      = 1'b1;

   // Widest state supported by the helper; callers truncate to their own N.
   localparam int MAX_N = 64;

   // Reset state: all zeros for Johnson, one-hot bit 0 for ring.
   function automatic logic [MAX_N-1:0] rst_state(input logic mode, input int n);
      logic [MAX_N-1:0] r;
      r = '0;
      if ((mode == MODE_RING) && (n >= 1)) begin
         r[0] = 1'b1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/twisted_ring_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : twisted_ring_counter_if
// Purpose  : Control and status bundle of the twisted ring counter.
// Revision : 1.0 - initial release
// ============================================================================
interface twisted_ring_counter_if #(
   parameter int N = 4
);
   localparam int IW = $clog2(2*N);

   logic          mode;
   logic          en;
   logic          dir;
   logic          load;
   logic [N-1:0]  load_val;
   logic [N-1:0]  Q;
   logic [IW-1:0] index;
   logic          wrap;
   logic          illegal;

   modport master (
      output mode, en, dir, load, load_val,
      input  Q, index, wrap, illegal
   );

   modport slave (
      input  mode, en, dir, load, load_val,
      output Q, index, wrap, illegal
   );

endinterface
`default_nettype wire

// File: rtl/trc_decode.sv
`default_nettype none
// ============================================================================
// Module   : trc_decode
// Purpose  : Combinational step-index and legality decode of the counter state.
// Revision : 1.0 - initial release
// ============================================================================
module trc_decode
   import twisted_ring_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]            q,
   input  logic                    mode_q,
   output logic [$clog2(2*N)-1:0]  index,
   output logic                    legal
);

   localparam int IW = $clog2(2*N);

   always_comb begin : p_decode
      int k;
      int p;
      int trans;
      int idx;
      k     = 0;
      p     = 0;
      trans = 0;
      idx   = 0;
      legal = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (q[i]) k = k + 1;
      end
      for (int i = N-1; i >= 0; i--) begin
         if (q[i]) p = i;
      end
      // Legal Johnson states are exactly those with at most one 0/1 boundary.
      for (int i = 0; i < N-1; i++) begin
         if (q[i] != q[i+1]) trans = trans + 1;
      end
      if (mode_q == MODE_JOHNSON) begin
         legal = (trans <= 1);
         if (q[N-1])      idx = k;
         else if (k == 0) idx = 0;
         else             idx = 2*N - k;
      end else begin
         legal = (k == 1);
         idx   = (N - p) % N;
      end
      index = legal ? IW'(idx) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/twisted_ring_counter.sv
`default_nettype none
// ============================================================================
// Module   : twisted_ring_counter
// Purpose  : Johnson/ring shift counter with load, direction, index and wrap.
//            Optional self-correction of illegal states: TRC_SELF_CORRECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module twisted_ring_counter
   import twisted_ring_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  clear,
   twisted_ring_counter_if.slave bus
);

   localparam int IW = $clog2(2*N);

   logic [N-1:0]  r_q;
   logic          r_mode_q;
   logic          r_wrap;

   logic [N-1:0]  w_rst_new;
   logic [N-1:0]  w_rst_cur;
   logic [N-1:0]  w_shift;
   logic [IW-1:0] w_index;
   logic          w_legal;
   logic          w_illegal;

   assign w_rst_new = N'(rst_state(bus.mode, N));
   assign w_rst_cur = N'(rst_state(r_mode_q, N));

   // Johnson inverts the bit wrapping around; ring passes it through.
   assign w_shift = (bus.dir == DIR_REV) ? {r_q[N-2:0], r_q[N-1] ^ r_mode_q}
                                         : {r_q[0] ^ r_mode_q, r_q[N-1:1]};

   trc_decode #(.N(N)) u_decode (
      .q      (r_q),
      .mode_q (r_mode_q),
      .index  (w_index),
      .legal  (w_legal)
   );

`ifdef TRC_SELF_CORRECT_EN
   assign w_illegal = ~w_legal;
`else
   logic w_unused_legal;
   assign w_unused_legal = w_legal;
   assign w_illegal      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clear || (bus.mode != r_mode_q)) begin
         r_q      <= w_rst_new;
         r_mode_q <= bus.mode;
         r_wrap   <= 1'b0;
      end else if (bus.load) begin
         r_q    <= bus.load_val;
         r_wrap <= 1'b0;
      end else if (bus.en) begin
         if (w_illegal) begin
            r_q    <= w_rst_cur;
            r_wrap <= 1'b0;
         end else begin
            r_q    <= w_shift;
            r_wrap <= (w_shift == w_rst_cur);
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign bus.Q       = r_q;
   assign bus.index   = w_index;
   assign bus.wrap    = r_wrap;
   assign bus.illegal = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_twisted_ring_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_twisted_ring_counter
// Purpose  : Directed self-checking bench for twisted_ring_counter, N = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twisted_ring_counter;

   localparam int N = 4;

   logic clk;
   logic clear;
   int   errors;
   int   checks;

   twisted_ring_counter_if #(.N(N)) bus ();

   twisted_ring_counter #(.N(N)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] q, input logic [2:0] idx,
                            input logic wr, input logic ill);
      check({tag, ".Q"},       32'(bus.Q),       32'(q));
      check({tag, ".index"},   32'(bus.index),   32'(idx));
      check({tag, ".wrap"},    32'(bus.wrap),    32'(wr));
      check({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
   endtask

   initial begin
      logic [3:0] jq [8];
      logic [2:0] ji [8];
      logic [3:0] rq [5];
      logic [2:0] ri [5];
      errors = 0;
      checks = 0;
      jq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
      ji = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      rq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
      ri = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3};

      clear        = 1'b1;
      bus.mode     = 1'b1;
      bus.en       = 1'b0;
      bus.dir      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = 4'b0000;
      step();
      check_all("reset_j", 4'b0000, 3'd0, 1'b0, 1'b0);

      // Johnson forward, full period
      clear  = 1'b0;
      bus.en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check_all($sformatf("jfwd%0d", i), jq[i], ji[i], (i == 7), 1'b0);
      end

      // Johnson reverse from 0000
      bus.dir = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_all($sformatf("jrev%0d", i), rq[i], ri[i], 1'b0, 1'b0);
      end

      bus.en = 1'b0;
      step();
      check_all("hold", 4'b1110, 3'd3, 1'b0, 1'b0);

      bus.load     = 1'b1;
      bus.load_val = 4'b1100;
      step();
      check_all("load1100", 4'b1100, 3'd2, 1'b0, 1'b0);

      // Mode flip to ring with a simultaneous load: load ignored
      bus.mode     = 1'b0;
      bus.load_val = 4'b1010;
      step();
      check_all("flip_ring", 4'b0001, 3'd0, 1'b0, 1'b0);
      bus.load = 1'b0;

      clear = 1'b1;
      step();
      check_all("reset_r", 4'b0001, 3'd0, 1'b0, 1'b0);
      clear   = 1'b0;
      bus.en  = 1'b1;
      bus.dir = 1'b0;
      step();
      check_all("rfwd0", 4'b1000, 3'd1, 1'b0, 1'b0);
      step();
      check_all("rfwd1", 4'b0100, 3'd2, 1'b0, 1'b0);
      step();
      check_all("rfwd2", 4'b0010, 3'd3, 1'b0, 1'b0);
      step();
      check_all("rfwd3", 4'b0001, 3'd0, 1'b1, 1'b0);
      bus.dir = 1'b1;
      step();
      check_all("rrev0", 4'b0010, 3'd3, 1'b0, 1'b0);

      // Back to Johnson while enabled: reset state, no wrap
      bus.mode = 1'b1;
      step();
      check_all("flip_j", 4'b0000, 3'd0, 1'b0, 1'b0);

      bus.en       = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 4'b1010;
      step();
`ifdef TRC_SELF_CORRECT_EN
      check_all("ld_illegal", 4'b1010, 3'd0, 1'b0, 1'b1);
`else
      check("ld_illegal.Q", 32'(bus.Q), 32'(4'b1010));
      check("ld_illegal.illegal", 32'(bus.illegal), 32'(1'b0));
`endif
      bus.load = 1'b0;
      bus.en   = 1'b1;
      bus.dir  = 1'b0;
      step();
`ifdef TRC_SELF_CORRECT_EN
      check_all("correct", 4'b0000, 3'd0, 1'b0, 1'b0);
`else
      check("illegal_shift.Q", 32'(bus.Q), 32'(4'b1101));
      check("illegal_shift.wrap", 32'(bus.wrap), 32'(1'b0));
      check("illegal_shift.illegal", 32'(bus.illegal), 32'(1'b0));
`endif

      // Load beats enable, then clear beats load
      bus.load     = 1'b1;
      bus.load_val = 4'b0110;
      step();
      check("ld_en.Q", 32'(bus.Q), 32'(4'b0110));
      clear = 1'b1;
      step();
      check_all("clr_wins", 4'b0000, 3'd0, 1'b0, 1'b0);

      // Wrap via reverse then forward, and drop when enable falls
      clear    = 1'b0;
      bus.load = 1'b0;
      bus.dir  = 1'b1;
      step();
      check_all("rev1", 4'b0001, 3'd7, 1'b0, 1'b0);
      bus.dir = 1'b0;
      step();
      check_all("fwd_wrap", 4'b0000, 3'd0, 1'b1, 1'b0);
      bus.en = 1'b0;
      step();
      check_all("wrap_drop", 4'b0000, 3'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
